// File: rtl/maple_txn_controller.sv
// Maple Bus port transaction sequencer.
// Arms the frame transmitter, owns the SDCKA/SDCKB pad output-enable, turns
// the bus around for a reply, enforces reply timeouts and reports exactly one
// completion status per transaction.
module maple_txn_controller #(
  parameter int C_TIMEOUT_TICKS    = 20000,
  parameter int C_TURNAROUND_TICKS = 16,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic       S_AXIS_ACLK,
  input  logic       S_AXIS_ARESETN,
  input  logic       START,
  input  logic       EXPECT_REPLY,
  input  logic       ABORT,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] STATUS,
  output logic       TX_ENABLE,
  input  logic       TX_BUSY,
  output logic       OE,
  output logic       RX_ENABLE,
  input  logic       RX_BUSY,
  input  logic       RX_DONE,
  input  logic       RX_ERROR
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_TX_ARM     = 3'd1,
    S_TX_RUN     = 3'd2,
    S_TURNAROUND = 3'd3,
    S_RX_WAIT    = 3'd4,
    S_RX_RUN     = 3'd5,
    S_FINISH     = 3'd6
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_RXERR   = 2'b10;
  localparam logic [1:0] ST_ABORTED = 2'b11;

  // Timer values on which the bounded states leave.
  localparam logic [C_CNT_WIDTH-1:0] TIMEOUT_LAST = C_CNT_WIDTH'(C_TIMEOUT_TICKS - 1);
  localparam logic [C_CNT_WIDTH-1:0] TURN_LAST    = C_CNT_WIDTH'(C_TURNAROUND_TICKS - 1);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE      = C_CNT_WIDTH'(1);

  // Output bundle order: {busy, done, tx_enable, oe, rx_enable}.
  localparam logic [4:0] OUTS_RESET = 5'b00010;

  // Moore output decode; evaluated on the next state so outputs come straight
  // from flops with no input-to-output path.
  function automatic logic [4:0] decode_outputs(input state_t s);
    logic [4:0] o;
    case (s)
      S_IDLE:       o = 5'b00010;
      S_TX_ARM:     o = 5'b10110;
      S_TX_RUN:     o = 5'b10010;
      S_TURNAROUND: o = 5'b10000;
      S_RX_WAIT:    o = 5'b10001;
      S_RX_RUN:     o = 5'b10001;
      S_FINISH:     o = 5'b11010;
      default:      o = 5'b00010;
    endcase
    return o;
  endfunction

  state_t                 state_q, state_d;
  logic [C_CNT_WIDTH-1:0] timer_q, timer_d;
  logic                   reply_q, reply_d;
  logic                   abort_q, abort_d;
  logic [1:0]             status_q, status_d;
  logic [4:0]             outs_q, outs_d;
  logic                   finish_s;
  logic [1:0]             fin_status_s;

  // Next-state logic, event priority and completion status selection.
  always_comb begin
    state_d      = state_q;
    reply_d      = reply_q;
    finish_s     = 1'b0;
    fin_status_s = ST_OK;
    case (state_q)
      S_IDLE: begin
        // ABORT has no meaning before a transaction is started.
        if (START) begin
          state_d = S_TX_ARM;
          reply_d = EXPECT_REPLY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TX_ARM: begin
        if (ABORT) begin
          finish_s     = 1'b1;
          fin_status_s = ST_ABORTED;
        end else if (TX_BUSY) begin
          state_d = S_TX_RUN;
        end else if (timer_q == TIMEOUT_LAST) begin
          finish_s     = 1'b1;
          fin_status_s = ST_TIMEOUT;
        end else begin
          state_d = S_TX_ARM;
        end
      end
      S_TX_RUN: begin
        // The frame cannot be cut short; an abort only takes effect once the
        // transmitter has released the line.
        if (TX_BUSY) begin
          state_d = S_TX_RUN;
        end else if (abort_q || ABORT) begin
          finish_s     = 1'b1;
          fin_status_s = ST_ABORTED;
        end else if (reply_q) begin
          state_d = S_TURNAROUND;
        end else begin
          finish_s     = 1'b1;
          fin_status_s = ST_OK;
        end
      end
      S_TURNAROUND: begin
        if (ABORT) begin
          finish_s     = 1'b1;
          fin_status_s = ST_ABORTED;
        end else if (timer_q == TURN_LAST) begin
          state_d = S_RX_WAIT;
        end else begin
          state_d = S_TURNAROUND;
        end
      end
      S_RX_WAIT: begin
        if (ABORT) begin
          finish_s     = 1'b1;
          fin_status_s = ST_ABORTED;
        end else if (RX_ERROR) begin
          finish_s     = 1'b1;
          fin_status_s = ST_RXERR;
        end else if (RX_DONE) begin
          finish_s     = 1'b1;
          fin_status_s = ST_OK;
        end else if (RX_BUSY) begin
          state_d = S_RX_RUN;
        end else if (timer_q == TIMEOUT_LAST) begin
          finish_s     = 1'b1;
          fin_status_s = ST_TIMEOUT;
        end else begin
          state_d = S_RX_WAIT;
        end
      end
      S_RX_RUN: begin
        // No timeout here: the receiver always terminates a started frame.
        if (ABORT) begin
          finish_s     = 1'b1;
          fin_status_s = ST_ABORTED;
        end else if (RX_ERROR) begin
          finish_s     = 1'b1;
          fin_status_s = ST_RXERR;
        end else if (RX_DONE) begin
          finish_s     = 1'b1;
          fin_status_s = ST_OK;
        end else begin
          state_d = S_RX_RUN;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish_s) begin
      state_d  = S_FINISH;
      status_d = fin_status_s;
    end else begin
      status_d = status_q;
    end
  end

  // Abort latch: collects ABORT while the frame is on the wire, empty elsewhere.
  always_comb begin
    if (state_q == S_TX_RUN) begin
      abort_d = abort_q | ABORT;
    end else begin
      abort_d = 1'b0;
    end
  end

  // State timer: restarts on every state change, counts otherwise.
  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + CNT_ONE;
    end
  end

  // Registered output decode of the upcoming state.
  always_comb begin
    outs_d = decode_outputs(state_d);
  end

  // State, timer, latches and output registers.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      reply_q  <= 1'b0;
      abort_q  <= 1'b0;
      status_q <= ST_OK;
      outs_q   <= OUTS_RESET;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      reply_q  <= reply_d;
      abort_q  <= abort_d;
      status_q <= status_d;
      outs_q   <= outs_d;
    end
  end

  assign BUSY      = outs_q[4];
  assign DONE      = outs_q[3];
  assign TX_ENABLE = outs_q[2];
  assign OE        = outs_q[1];
  assign RX_ENABLE = outs_q[0];
  assign STATUS    = status_q;

endmodule

// File: tb/tb_maple_txn_controller.sv
// Directed bench for maple_txn_controller (timeout 100, turnaround 4).
module tb_maple_txn_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       expect_reply;
  logic       abort;
  logic       tx_busy;
  logic       rx_busy;
  logic       rx_done;
  logic       rx_error;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic       tx_enable;
  logic       oe;
  logic       rx_enable;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  // Inputs: {start, expect_reply, abort, tx_busy, rx_busy, rx_done, rx_error}
  // Expected: {busy, done, status[1:0], tx_enable, oe, rx_enable}
  typedef struct packed {
    logic [6:0] in_bits;
    logic [6:0] exp_bits;
  } vec_t;

  vec_t vecs [20];

  maple_txn_controller #(
    .C_TIMEOUT_TICKS   (100),
    .C_TURNAROUND_TICKS(4),
    .C_CNT_WIDTH       (16)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .START         (start),
    .EXPECT_REPLY  (expect_reply),
    .ABORT         (abort),
    .BUSY          (busy),
    .DONE          (done),
    .STATUS        (status),
    .TX_ENABLE     (tx_enable),
    .TX_BUSY       (tx_busy),
    .OE            (oe),
    .RX_ENABLE     (rx_enable),
    .RX_BUSY       (rx_busy),
    .RX_DONE       (rx_done),
    .RX_ERROR      (rx_error)
  );

  assign outs = {busy, done, status, tx_enable, oe, rx_enable};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  initial begin
    logic bad;

    rst_n = 1'b0; start = 1'b0; expect_reply = 1'b0; abort = 1'b0;
    tx_busy = 1'b0; rx_busy = 1'b0; rx_done = 1'b0; rx_error = 1'b0;

    vecs[0]  = {7'b1100000, 7'b1000110}; // START, reply wanted -> TX_ARM
    vecs[1]  = {7'b0000000, 7'b1000110}; // still arming
    vecs[2]  = {7'b0001000, 7'b1000010}; // TX_BUSY -> TX_RUN
    vecs[3]  = {7'b1001000, 7'b1000010}; // START dropped in TX_RUN
    vecs[4]  = {7'b0000000, 7'b1000000}; // TX done -> TURNAROUND, OE low
    vecs[5]  = {7'b0000000, 7'b1000000};
    vecs[6]  = {7'b0000000, 7'b1000000};
    vecs[7]  = {7'b0000000, 7'b1000000}; // 4th turnaround cycle
    vecs[8]  = {7'b0000000, 7'b1000001}; // RX_WAIT, RX_ENABLE high
    vecs[9]  = {7'b0000100, 7'b1000001}; // RX_BUSY -> RX_RUN
    vecs[10] = {7'b1000000, 7'b1000001}; // START ignored in RX_RUN
    vecs[11] = {7'b0000010, 7'b1100010}; // RX_DONE -> FINISH ok, OE back
    vecs[12] = {7'b0000000, 7'b0000010}; // IDLE
    vecs[13] = {7'b1000000, 7'b1000110}; // START no reply
    vecs[14] = {7'b0010000, 7'b1111010}; // ABORT in TX_ARM -> FINISH 11
    vecs[15] = {7'b0000000, 7'b0011010}; // IDLE, status held
    vecs[16] = {7'b1010000, 7'b1011110}; // START+ABORT in IDLE: abort ignored
    vecs[17] = {7'b0001000, 7'b1011010}; // TX_RUN
    vecs[18] = {7'b0000000, 7'b1100010}; // no reply -> FINISH 00
    vecs[19] = {7'b0000000, 7'b0000010}; // IDLE

    repeat (3) tick();
    check("reset_state", outs, 7'b0000010);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", outs, 7'b0000010);

    // Table-driven cycle-by-cycle sequence.
    for (int i = 0; i < 20; i++) begin
      {start, expect_reply, abort, tx_busy, rx_busy, rx_done, rx_error} = vecs[i].in_bits;
      tick();
      check($sformatf("vec%0d", i), outs, vecs[i].exp_bits);
    end
    {start, expect_reply, abort, tx_busy, rx_busy, rx_done, rx_error} = 7'b0000000;

    // TX timeout: TX_BUSY never rises.
    start = 1'b1; expect_reply = 1'b0;
    tick();
    start = 1'b0;
    check("txto_arm", outs, 7'b1000110);
    bad = 1'b0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (done !== 1'b0 || tx_enable !== 1'b1) bad = 1'b1;
    end
    check("txto_no_early_done", 7'(bad), 7'b0000000);
    tick();
    check("txto_done", outs, 7'b1101010);
    tick();
    check("txto_idle", outs, 7'b0001010);

    // No-reply transaction with a 50-cycle frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tx_busy = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (oe !== 1'b1 || rx_enable !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    tx_busy = 1'b0;
    tick();
    check("norep_done", outs, 7'b1100010);
    if (oe !== 1'b1 || rx_enable !== 1'b0) bad = 1'b1;
    tick();
    check("norep_idle", outs, 7'b0000010);
    check("norep_oe_rx_steady", 7'(bad), 7'b0000000);

    // RX timeout: RX_BUSY never rises.
    start = 1'b1; expect_reply = 1'b1;
    tick();
    start = 1'b0; expect_reply = 1'b0; tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
    check("rxto_turnaround", outs, 7'b1000000);
    repeat (4) tick();
    check("rxto_rx_wait", outs, 7'b1000001);
    bad = 1'b0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (done !== 1'b0 || rx_enable !== 1'b1) bad = 1'b1;
    end
    check("rxto_no_early_done", 7'(bad), 7'b0000000);
    tick();
    check("rxto_done", outs, 7'b1101010);
    tick();

    // Abort during TX_RUN with a reply expected.
    start = 1'b1; expect_reply = 1'b1;
    tick();
    start = 1'b0; expect_reply = 1'b0; tx_busy = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abrt_held_in_tx_run", outs, 7'b1001010);
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (done !== 1'b0) bad = 1'b1;
    end
    check("abrt_no_early_done", 7'(bad), 7'b0000000);
    tx_busy = 1'b0;
    tick();
    check("abrt_done_skip_turnaround", outs, 7'b1111010);
    tick();

    // RX_ERROR and RX_DONE together in RX_RUN.
    start = 1'b1; expect_reply = 1'b1;
    tick();
    start = 1'b0; expect_reply = 1'b0; tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
    repeat (4) tick();
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    check("simul_rx_run", outs, 7'b1011001);
    rx_error = 1'b1; rx_done = 1'b1;
    tick();
    rx_error = 1'b0; rx_done = 1'b0;
    check("simul_rx_error_wins", outs, 7'b1110010);
    tick();
    check("simul_idle", outs, 7'b0010010);

    // Reset asserted during TURNAROUND.
    start = 1'b1; expect_reply = 1'b1;
    tick();
    start = 1'b0; expect_reply = 1'b0; tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
    tick();
    check("rst_in_turnaround", outs, 7'b1010000);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_immediate", outs, 7'b0000010);
    bad = 1'b0;
    repeat (2) begin
      tick();
      if (done !== 1'b0) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      if (done !== 1'b0) bad = 1'b1;
    end
    check("rst_no_done", 7'(bad), 7'b0000000);
    check("rst_idle", outs, 7'b0000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maple_txn_controller.md
# maple_txn_controller

Transaction sequencer for one Maple Bus port. It arms the frame transmitter and owns the SDCKA/SDCKB pad output-enable. After transmission it turns the bus around and hands it to the frame receiver. It enforces reply timeouts and reports one completion status per transaction. It sits between the port's host-side command logic and the transmitter/receiver pair, and is the only block allowed to drive the transmitter's ENABLE and the pad OE.

## Interface
Parameters:
- C_TIMEOUT_TICKS, 20000 — cycles allowed in TX_ARM or RX_WAIT before timeout; must be ≥ 2.
- C_TURNAROUND_TICKS, 16 — cycles with pads released before the receiver is enabled; must be ≥ 1.
- C_CNT_WIDTH, 16 — timer width; must hold max(C_TIMEOUT_TICKS, C_TURNAROUND_TICKS).

Ports:
- S_AXIS_ACLK  in  1  clock; one clock domain for the whole block.
- S_AXIS_ARESETN  in  1  reset; asynchronous, active-low.
- START  in  1  request a transaction; sampled only in IDLE.
- EXPECT_REPLY  in  1  sampled with START; 1 = receive a reply after transmitting.
- ABORT  in  1  cancel the current transaction.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- STATUS  out  2  00 ok, 01 timeout, 10 rx error, 11 aborted; valid from the DONE cycle, held until the next DONE.
- TX_ENABLE  out  1  connect to the transmitter ENABLE.
- TX_BUSY  in  1  connect to the transmitter TRANSMITTING.
- OE  out  1  pad drive enable for SDCKA/SDCKB; 1 = host drives.
- RX_ENABLE  out  1  arms the receiver.
- RX_BUSY  in  1  receiver has detected a start pattern.
- RX_DONE  in  1  one-cycle pulse: frame received correctly.
- RX_ERROR  in  1  one-cycle pulse: frame error.

## Operation
Moore FSM with states IDLE, TX_ARM, TX_RUN, TURNAROUND, RX_WAIT, RX_RUN, FINISH. A single timer clears on every state entry and increments each cycle otherwise.

State behaviour and transitions:
- **IDLE**
  - Outputs: OE=1, all other outputs 0.
  - START=1 → TX_ARM; EXPECT_REPLY is latched in the same cycle.
  - ABORT is ignored in IDLE, including when it coincides with START.
- **TX_ARM**
  - Outputs: TX_ENABLE=1, OE=1.
  - TX_BUSY=1 → TX_RUN.
  - Otherwise, after C_TIMEOUT_TICKS cycles in the state (stream never valid) → FINISH with STATUS 01.
  - ABORT → FINISH with STATUS 11.
- **TX_RUN**
  - Outputs: TX_ENABLE=0, OE=1.
  - ABORT is latched here, not acted on, because the transmitter cannot be stopped mid-frame.
  - When TX_BUSY=0: abort latched → FINISH 11; else reply expected → TURNAROUND; else → FINISH 00.
- **TURNAROUND**
  - Outputs: OE=0.
  - After exactly C_TURNAROUND_TICKS cycles → RX_WAIT.
  - ABORT → FINISH 11.
- **RX_WAIT**
  - Outputs: OE=0, RX_ENABLE=1.
  - RX_BUSY=1 → RX_RUN.
  - After C_TIMEOUT_TICKS cycles → FINISH 01.
  - RX_DONE or RX_ERROR here is handled exactly as in RX_RUN.
  - ABORT → FINISH 11.
- **RX_RUN**
  - Outputs: OE=0, RX_ENABLE=1.
  - RX_ERROR → FINISH 10.
  - RX_DONE → FINISH 00.
  - There is no timeout in RX_RUN; the receiver guarantees termination.
  - ABORT → FINISH 11.
- **FINISH**
  - Outputs: DONE=1, OE=1; STATUS is updated on entry.
  - Next cycle → IDLE.

Priority when events coincide in one cycle:
- ABORT > RX_ERROR > RX_DONE > RX_BUSY > timer expiry.
- TX_BUSY rising beats timer expiry in TX_ARM.
- START arriving in any state other than IDLE is dropped; there is no queueing.

## Timing
- Reset (asynchronous assert; deassert sampled on the clock):
  - State IDLE; BUSY=0, DONE=0, STATUS=00, TX_ENABLE=0, RX_ENABLE=0, OE=1.
  - The latched EXPECT_REPLY and the abort latch clear.
  - Reset mid-transaction returns immediately to these values; no DONE is generated.
- START latency:
  - START sampled at edge n → TX_ENABLE and BUSY high from cycle n+1.
  - With a valid stream, TX_BUSY is expected at n+3.
- Outputs are pure decodes of the state register (glitch-free, no input-to-output paths). STATUS and DONE are registered.
- Timeout: expiry is taken on the cycle the timer equals C_TIMEOUT_TICKS-1, giving exactly C_TIMEOUT_TICKS cycles in the state.
- Turnaround: OE falls on the first TX_RUN→TURNAROUND cycle. RX_ENABLE rises C_TURNAROUND_TICKS cycles later.
- Back-to-back: FINISH lasts 1 cycle and IDLE at least 1 cycle, so a new START is accepted no earlier than 2 cycles after DONE.

## Test plan
All scenarios use C_TIMEOUT_TICKS=100, C_TURNAROUND_TICKS=4.
- **No-reply transaction.** START with EXPECT_REPLY=0; TX_BUSY high for 50 cycles → DONE one cycle after TX_BUSY falls, STATUS=00, OE never drops, RX_ENABLE never rises.
- **Reply transaction.** START with EXPECT_REPLY=1; after TX_BUSY falls, OE=0 for 4 cycles before RX_ENABLE=1; RX_BUSY then RX_DONE → DONE, STATUS=00, OE returns to 1 in the DONE cycle.
- **Timeouts.**
  - TX_BUSY never rises → DONE exactly 100 cycles after TX_ENABLE rises, STATUS=01.
  - In a separate run, RX_BUSY never rises → DONE after 100 RX_WAIT cycles, STATUS=01.
- **Abort during TX_RUN.** ABORT pulsed while TX_BUSY=1 → no early DONE; DONE with STATUS=11 on TX_BUSY fall; TURNAROUND is skipped even with EXPECT_REPLY=1.
- **Simultaneous receive events.** RX_ERROR and RX_DONE in the same cycle → STATUS=10.
- **Ignored START and mid-transaction reset.** START pulsed in RX_RUN → ignored. Reset asserted in TURNAROUND → all outputs immediately at reset values, no DONE.
